// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct encodings, FSM states and decode helper for the EX-stage multiply/divide unit
package muldiv_pkg;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring-subtract divide
//   div        : 1 = divide step, 0 = multiply step
//   acc        : partial product high half / partial remainder
//   sreg       : multiplier being shifted out / dividend shifting into quotient
//   opnd       : multiplicand / divisor magnitude
//   next_acc, next_sreg : state after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sreg,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_acc,
    output logic [WIDTH-1:0] next_sreg
);
    logic [WIDTH:0] sum, shifted, diff;

    assign sum     = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc, sreg[WIDTH-1]};
    // remainder stays below the divisor, so bit WIDTH of diff is a pure borrow flag
    assign diff    = shifted - {1'b0, opnd};

    assign next_acc  = div ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign next_sreg = div ? {sreg[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], sreg[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/multu/div/divu with HI/LO registers and pipeline stall
//   clk, resetn     : clock, asynchronous active-low reset
//   start, funct    : EX-stage valid and R-type funct
//   rs_val, rt_val  : operands A and B (A also sources mthi/mtlo)
//   flush           : kills the in-flight op at the next edge
//   busy            : combinational stall request
//   done            : one-cycle pulse when hi/lo hold the result
//   hi, lo          : HI and LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_div, neg_q, neg_r;
    logic [WIDTH-1:0]  opnd, acc, sreg, acc_n, sreg_n;
    logic              is_md, op_is_div, sgn_op;
    logic [WIDTH-1:0]  mag_a, mag_b, q_f, r_f, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_f;

    assign is_md     = is_md_funct(funct);
    assign op_is_div = funct == FUNCT_DIV || funct == FUNCT_DIVU;
    // signed divide by zero is run unsigned so the raw dividend lands in hi and lo is all ones
    assign sgn_op    = funct == FUNCT_MULT || (funct == FUNCT_DIV && |rt_val);
    assign mag_a     = (sgn_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign mag_b     = (sgn_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign busy = state == ST_RUN || state == ST_FIX || (state == ST_IDLE && start && is_md);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div       (op_div),
        .acc       (acc),
        .sreg      (sreg),
        .opnd      (opnd),
        .next_acc  (acc_n),
        .next_sreg (sreg_n)
    );

    // sign correction; MIN/-1 falls out as quotient MIN, remainder 0
    assign prod_f = neg_q ? -{acc, sreg} : {acc, sreg};
    assign q_f    = neg_q ? -sreg : sreg;
    assign r_f    = neg_r ? -acc : acc;
    assign res_hi = op_div ? r_f : prod_f[2*WIDTH-1:WIDTH];
    assign res_lo = op_div ? q_f : prod_f[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            sreg   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && is_md) begin
                            state  <= ST_RUN;
                            cnt    <= '0;
                            op_div <= op_is_div;
                            neg_q  <= sgn_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            neg_r  <= sgn_op && op_is_div && rs_val[WIDTH-1];
                            acc    <= '0;
                            sreg   <= mag_a;
                            opnd   <= mag_b;
                        end else if (start && funct == FUNCT_MTHI) begin
                            hi <= rs_val;
                        end else if (start && funct == FUNCT_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                    ST_RUN: begin
                        acc  <= acc_n;
                        sreg <= sreg_n;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, start, flush, busy, done;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val, hi, lo;
    int          errors = 0;
    int          checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; that cycle is cycle 0. Start is held until done is seen.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int nb, lb, dc, nd;
        logic [31:0] dh, dl;
        nb = 0; lb = -1; dc = -1; nd = 0; dh = '0; dl = '0;
        funct = f; rs_val = a; rt_val = b; start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            #4;
            if (busy) begin nb++; lb = c; end
            if (done) begin
                nd++;
                if (dc < 0) begin dc = c; dh = hi; dl = lo; end
            end
            @(posedge clk); #1;
            if (c == 0) begin rs_val = 32'h5A5A_A5A5; rt_val = 32'h0000_0003; end
            if (dc >= 0) start = 1'b0;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(nb), 64'd34);
        check({tag, " last_busy"}, 64'(lb), 64'd33);
        check({tag, " done_cycle"}, 64'(dc), 64'd34);
        check({tag, " done_count"}, 64'(nd), 64'd1);
        check({tag, " hi"}, 64'(dh), 64'(eh));
        check({tag, " lo"}, 64'(dl), 64'(el));
    endtask

    initial begin
        int nb, nd;
        resetn = 1'b0; start = 1'b0; flush = 1'b0; funct = '0; rs_val = '0; rt_val = '0;
        #2;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        run_op("mult", FUNCT_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", FUNCT_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", FUNCT_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", FUNCT_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("divs0", FUNCT_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("mults", FUNCT_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // mthi / mtlo
        funct = FUNCT_MTHI; rs_val = 32'h0000_1234; start = 1'b1;
        #4 check("mthi busy", 64'(busy), 64'd0);
        @(posedge clk); #1 start = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo", 64'(lo), 64'hFFFF_FFEB);
        check("mthi busy after", 64'(busy), 64'd0);
        funct = FUNCT_MTLO; rs_val = 32'h0000_5678; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("mtlo lo", 64'(lo), 64'h5678);
        check("mtlo hi", 64'(hi), 64'h1234);
        funct = FUNCT_MTHI; rs_val = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        check("flush mthi hi", 64'(hi), 64'h1234);

        // flush in cycle 10 of a mult
        funct = FUNCT_MULT; rs_val = 32'h0000_0009; rt_val = 32'h0000_0009; start = 1'b1;
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        flush = 1'b1; start = 1'b0;
        #4 check("flush c10 busy", 64'(busy), 64'd1);
        @(posedge clk); #1 flush = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (busy) nb++;
            if (done) nd++;
            @(posedge clk); #1;
        end
        check("flush busy after", 64'(nb), 64'd0);
        check("flush done", 64'(nd), 64'd0);
        check("flush hi", 64'(hi), 64'h1234);
        check("flush lo", 64'(lo), 64'h5678);
        run_op("mult after flush", FUNCT_MULT, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F);

        // async reset mid-run
        funct = FUNCT_MULT; rs_val = 32'h0000_0011; rt_val = 32'h0000_0022; start = 1'b1;
        for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
        start = 1'b0;
        #1 check("pre-reset busy", 64'(busy), 64'd1);
        #1 resetn = 1'b0;
        #1;
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        run_op("divu", FUNCT_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
